// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: operand reads, write ports, reservation and clear.
// The decode stage drives the master side; the register file is the slave.
interface register_file_mp_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_RD_PORTS  = 2,
    parameter int NUM_WR_PORTS  = 2
) ();
    logic [NUM_RD_PORTS*ADDRESS_WIDTH-1:0] rd_addr;
    logic [NUM_RD_PORTS*DATA_WIDTH-1:0]    rd_data;
    logic [NUM_RD_PORTS-1:0]               rd_busy;
    logic [NUM_WR_PORTS-1:0]               wr_en;
    logic [NUM_WR_PORTS*ADDRESS_WIDTH-1:0] wr_addr;
    logic [NUM_WR_PORTS*DATA_WIDTH-1:0]    wr_data;
    logic                                  rsv_en;
    logic [ADDRESS_WIDTH-1:0]              rsv_addr;
    logic                                  clr_req;
    logic                                  init_busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
        input  rd_data, rd_busy, init_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
        output rd_data, rd_busy, init_busy
    );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port general purpose register file with write-to-read bypass, optional
// hard-wired zero entry, per-register busy scoreboard and a sequential
// clear engine so the storage array itself carries no reset.
module register_file_mp #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_RD_PORTS  = 2,
    parameter int NUM_WR_PORTS  = 2,
    parameter int ZERO_REG      = 1
) (
    input  logic              clk,
    input  logic              rst,
    register_file_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam bit ZR    = (ZERO_REG != 0);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [ADDRESS_WIDTH-1:0]   r_clr_cnt;
    logic [ADDRESS_WIDTH-1:0]   w_clr_cnt_nxt;
    logic [DEPTH-1:0]           r_busy;
    logic [DEPTH-1:0]           w_busy_nxt;
    logic [DATA_WIDTH-1:0]      r_mem [DEPTH];
    logic                       w_run;

    logic [ADDRESS_WIDTH-1:0]   w_ra  [NUM_RD_PORTS];
    logic                       w_hit [NUM_RD_PORTS];
    logic [DATA_WIDTH-1:0]      w_byp [NUM_RD_PORTS];
    logic [NUM_RD_PORTS*DATA_WIDTH-1:0] w_rd_data;
    logic [NUM_RD_PORTS-1:0]            w_rd_busy;

    assign w_run         = (r_state == ST_RUN);
    assign bus.init_busy = ~w_run;
    assign bus.rd_data   = w_rd_data;
    assign bus.rd_busy   = w_rd_busy;

    // FSM state, clear counter and scoreboard; these are the only reset targets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_INIT;
            r_clr_cnt <= '0;
            r_busy    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next state: INIT sweeps every entry once, a clear request (re)starts the sweep.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            ST_INIT: begin
                if (bus.clr_req) begin
                    w_clr_cnt_nxt = '0;
                end else if (&r_clr_cnt) begin
                    w_state_nxt   = ST_RUN;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + ADDRESS_WIDTH'(1);
                end
            end
            ST_RUN: begin
                if (bus.clr_req) begin
                    w_state_nxt   = ST_INIT;
                    w_clr_cnt_nxt = '0;
                end
            end
        endcase
    end

    // Scoreboard update: writes retire producers, a reservation wins over a same-cycle write.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_run) begin
            if (bus.clr_req) begin
                w_busy_nxt = '0;
            end else begin
                for (int j = 0; j < NUM_WR_PORTS; j++) begin
                    if (bus.wr_en[j]) begin
                        w_busy_nxt[bus.wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH]] = 1'b0;
                    end
                end
                if (bus.rsv_en) begin
                    w_busy_nxt[bus.rsv_addr] = 1'b1;
                end
                if (ZR) begin
                    w_busy_nxt[0] = 1'b0;
                end
            end
        end
    end

    // Storage: zero fill while sweeping, otherwise port-ordered writes so the highest port lands last.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (!bus.clr_req) begin
            for (int j = 0; j < NUM_WR_PORTS; j++) begin
                if (bus.wr_en[j] &&
                    !(ZR && (bus.wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH] == '0))) begin
                    r_mem[bus.wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH]] <=
                        bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Read ports: zero register, then highest-port bypass, then stored value; bypass hides busy.
    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        for (int i = 0; i < NUM_RD_PORTS; i++) begin
            w_ra[i]  = bus.rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            w_hit[i] = 1'b0;
            w_byp[i] = '0;
            for (int j = 0; j < NUM_WR_PORTS; j++) begin
                if (bus.wr_en[j] &&
                    (bus.wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH] == w_ra[i])) begin
                    w_hit[i] = 1'b1;
                    w_byp[i] = bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (w_run && !(ZR && (w_ra[i] == '0))) begin
                w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = w_hit[i] ? w_byp[i] : r_mem[w_ra[i]];
                w_rd_busy[i] = r_busy[w_ra[i]] & ~w_hit[i];
            end
        end
    end
endmodule

// File: tb/tb_register_file_mp.sv
// Randomised plus directed bench for register_file_mp with a queue-based scoreboard.
module tb_register_file_mp;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int DEPTH = 32;

    typedef struct packed {
        logic [NRD*DW-1:0] data;
        logic [NRD-1:0]    busy;
        logic              ib;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    register_file_mp_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
                          .NUM_RD_PORTS(NRD), .NUM_WR_PORTS(NWR)) bus ();

    register_file_mp #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_RD_PORTS(NRD),
                       .NUM_WR_PORTS(NWR), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: the file is either usable (m_init == 0) or in a clear
    // period with m_init cycles left; entering a clear period zeroes everything.
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];
    int            m_init;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void m_enter_init();
        for (int k = 0; k < DEPTH; k++) begin
            m_mem[k]  = '0;
            m_busy[k] = 1'b0;
        end
        m_init = DEPTH;
    endfunction

    function automatic exp_t m_expect();
        exp_t e;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit hit;
        e.data = '0;
        e.busy = '0;
        e.ib   = (m_init > 0);
        if (m_init == 0) begin
            for (int i = 0; i < NRD; i++) begin
                a = bus.rd_addr[i*AW +: AW];
                if (a != 0) begin
                    hit = 1'b0;
                    d   = m_mem[a];
                    for (int j = 0; j < NWR; j++) begin
                        if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == a) begin
                            hit = 1'b1;
                            d   = bus.wr_data[j*DW +: DW];
                        end
                    end
                    e.data[i*DW +: DW] = d;
                    e.busy[i] = m_busy[a] && !hit;
                end
            end
        end
        return e;
    endfunction

    function automatic void m_advance();
        logic [AW-1:0] a;
        if (rst) begin
            m_enter_init();
        end else if (m_init > 0) begin
            if (bus.clr_req) m_init = DEPTH;
            else m_init--;
        end else if (bus.clr_req) begin
            m_enter_init();
        end else begin
            for (int j = 0; j < NWR; j++) begin
                a = bus.wr_addr[j*AW +: AW];
                if (bus.wr_en[j]) begin
                    if (a != 0) m_mem[a] = bus.wr_data[j*DW +: DW];
                    m_busy[a] = 1'b0;
                end
            end
            if (bus.rsv_en && bus.rsv_addr != 0) m_busy[bus.rsv_addr] = 1'b1;
        end
    endfunction

    // One cycle: current inputs are already driven; queue the expectation, then advance.
    task automatic step();
        if (rst) m_enter_init();
        sb_q.push_back(m_expect());
        @(posedge clk);
        m_advance();
        #1;
    endtask

    task automatic idle();
        bus.wr_en   = '0;
        bus.rsv_en  = 1'b0;
        bus.clr_req = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.rd_addr = {a1, a0};
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_en[p]            = 1'b1;
        bus.wr_addr[p*AW +: AW] = a;
        bus.wr_data[p*DW +: DW] = d;
    endtask

    task automatic idle_rand(input int n);
        for (int k = 0; k < n; k++) begin
            idle();
            bus.rd_addr = NRD*AW'($urandom);
            step();
        end
    endtask

    task automatic read_all();
        idle();
        for (int a = 0; a < DEPTH; a += 2) begin
            rd(AW'(a), AW'(a + 1));
            step();
        end
    endtask

    // Monitor: the outputs are combinational, so each queued expectation is due mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (bus.rd_data !== e.data) begin
                n_bad++;
                $display("FAIL rd_data t=%0t addr=%h got %h want %h", $time, bus.rd_addr, bus.rd_data, e.data);
            end
            n_cmp++;
            if (bus.rd_busy !== e.busy) begin
                n_bad++;
                $display("FAIL rd_busy t=%0t addr=%h got %b want %b", $time, bus.rd_addr, bus.rd_busy, e.busy);
            end
            n_cmp++;
            if (bus.init_busy !== e.ib) begin
                n_bad++;
                $display("FAIL init_busy t=%0t got %b want %b", $time, bus.init_busy, e.ib);
            end
        end
    end

    initial begin
        bus.rd_addr  = '0;
        bus.wr_en    = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rsv_en   = 1'b0;
        bus.rsv_addr = '0;
        bus.clr_req  = 1'b0;
        m_enter_init();

        // Power-on reset and first sweep
        rst = 1'b1;
        step(); step(); step();
        rst = 1'b0;
        idle_rand(34);
        read_all();

        // Two ports writing the same address: port 1 wins in bypass and storage
        idle();
        wr(0, 5'd5, 32'hDEADBEEF);
        wr(1, 5'd5, 32'h12345678);
        rd(5'd5, 5'd5);
        step();
        idle(); rd(5'd5, 5'd4); step();

        // Scoreboard: reserve, bypass hides busy, write clears, reserve+write keeps busy
        idle(); bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7; rd(5'd7, 5'd6); step();
        idle(); rd(5'd7, 5'd7); step();
        idle(); wr(0, 5'd7, 32'h000000A5); rd(5'd7, 5'd3); step();
        idle(); rd(5'd7, 5'd7); step();
        idle(); wr(1, 5'd7, 32'h0000005A); bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7; step();
        idle(); rd(5'd7, 5'd8); step();

        // Zero register ignores writes and reservations
        idle(); wr(1, 5'd0, 32'hFFFFFFFF); rd(5'd0, 5'd0); step();
        idle(); bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0; rd(5'd0, 5'd0); step();
        idle(); rd(5'd0, 5'd0); step();
        step();

        // Randomised traffic with occasional clears
        for (int k = 0; k < 600; k++) begin
            idle();
            bus.rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            bus.wr_en   = NWR'($urandom);
            bus.wr_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            bus.wr_data = {$urandom, $urandom};
            bus.rsv_en  = ($urandom_range(0, 3) == 0);
            bus.rsv_addr = AW'($urandom_range(0, 7));
            bus.clr_req = ($urandom_range(0, 79) == 0);
            step();
        end
        idle_rand(34);

        // Fill 1..3, clear, writes ignored during the sweep, restart at cycle 10
        idle(); wr(0, 5'd1, 32'h11); wr(1, 5'd2, 32'h22); step();
        idle(); wr(0, 5'd3, 32'h33); rd(5'd1, 5'd2); step();
        idle(); rd(5'd3, 5'd1); step();
        idle(); bus.clr_req = 1'b1; step();
        for (int k = 1; k < 10; k++) begin
            idle();
            wr(0, AW'(k), 32'hCAFE0000 + k);
            bus.rsv_en = 1'b1; bus.rsv_addr = AW'(k + 1);
            rd(AW'(k), 5'd3);
            step();
        end
        idle(); bus.clr_req = 1'b1; step();
        idle_rand(34);
        read_all();

        // Reset in the middle of a sweep, held three cycles
        idle(); bus.clr_req = 1'b1; step();
        idle_rand(19);
        rst = 1'b1;
        idle_rand(3);
        rst = 1'b0;
        idle_rand(34);
        read_all();

        @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain left %0d want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised multi-port general purpose register file, the successor to the uDLX two-write/two-read register bank.
- Configurable counts of read and write ports.
- Write-to-read bypass with defined same-address write priority.
- Optional hard-wired zero register.
- Per-register busy scoreboard for in-flight producers.
- Sequential initialisation/clear engine, so storage needs no reset fan-out and maps to distributed RAM.
- Sits in the decode stage; feeds operand reads and the hazard unit.

Parameters:
- DATA_WIDTH, 32: register width in bits.
- ADDRESS_WIDTH, 5: address bits; depth = 2**ADDRESS_WIDTH.
- NUM_RD_PORTS, 2: number of combinational read ports, at least 1.
- NUM_WR_PORTS, 2: number of synchronous write ports, at least 1.
- ZERO_REG, 1: if 1, entry 0 always reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- rd_addr  in  NUM_RD_PORTS*ADDRESS_WIDTH  read addresses; port i uses slice [i*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- rd_data  out  NUM_RD_PORTS*DATA_WIDTH  read data, combinational.
- rd_busy  out  NUM_RD_PORTS  addressed register has an outstanding reservation.
- wr_en  in  NUM_WR_PORTS  per-port write enable.
- wr_addr  in  NUM_WR_PORTS*ADDRESS_WIDTH  write addresses.
- wr_data  in  NUM_WR_PORTS*DATA_WIDTH  write data.
- rsv_en  in  1  reserve rsv_addr (sets its busy bit).
- rsv_addr  in  ADDRESS_WIDTH  register to reserve.
- clr_req  in  1  single-cycle request to re-zero all registers and clear the scoreboard.
- init_busy  out  1  init/clear engine active; the file is not usable.

Behaviour:
FSM:
- Two states, INIT and RUN, with a clear counter clr_cnt of ADDRESS_WIDTH bits.
- While rst is high: state = INIT, clr_cnt = 0, all busy bits = 0, init_busy = 1.
- Storage array has no reset.
- In INIT, each clock writes zero to entry clr_cnt, then clr_cnt increments.
- On the edge that writes entry 2**ADDRESS_WIDTH-1, the FSM moves to RUN and clr_cnt wraps to 0.
- INIT therefore lasts exactly 2**ADDRESS_WIDTH cycles after rst falls.
- init_busy = 1 exactly when state is INIT.
- clr_req in RUN: next edge enters INIT with clr_cnt = 0 and clears all busy bits. Writes and reservations in that same cycle are discarded.
- clr_req in INIT: restarts clr_cnt at 0 on the next edge.

INIT state:
- wr_en and rsv_en are ignored.
- rd_data = 0 and rd_busy = 0 on all ports.

RUN state, writes:
- Each port with wr_en[j] = 1 writes wr_data[j] to wr_addr[j] on the rising edge.
- If several ports write the same address in one cycle, the highest-index port wins, both in storage and in bypass.
- With ZERO_REG = 1, writes to address 0 are dropped.

RUN state, reads (combinational, zero latency):
- Priority order:
  1. ZERO_REG = 1 and address 0 -> 0.
  2. Otherwise, the highest-index write port with wr_en and a matching address -> its wr_data (bypass).
  3. Otherwise -> stored value.

RUN state, scoreboard (one busy bit per entry, registered):
- Set on rsv_en at rsv_addr.
- Cleared when any enabled write port targets that address.
- Reserve and write to the same address in the same cycle: the busy bit ends up set, because the new producer wins.
- With ZERO_REG = 1, address 0 is never set.
- rd_busy[i] = busy[rd_addr[i]] AND NOT (a same-cycle bypass hit on that port). A bypassed value is valid.

Other rules:
- No arithmetic beyond the clr_cnt increment, which wraps modulo 2**ADDRESS_WIDTH.
- Reset asserted mid-INIT or mid-RUN: the FSM and scoreboard return to reset values asynchronously, and INIT restarts after rst is released.

Test Plan:
- Reset, then release -> init_busy = 1 for exactly 32 cycles and 0 from cycle 33. All 32 registers then read 0 with rd_busy = 0.
- RUN, write port0 addr 5 = 0xDEADBEEF and port1 addr 5 = 0x12345678 in one cycle, with rd_addr port0 = 5 -> same cycle rd_data = 0x12345678. Next cycle stored value = 0x12345678.
- rsv_en addr 7 -> next cycle rd_busy = 1 for addr 7. Writing addr 7 = 0xA5 gives rd_busy = 0 and rd_data = 0xA5 in that cycle, and busy is clear afterwards. Reserve plus write to addr 7 in one cycle -> busy = 1 afterwards.
- ZERO_REG = 1: write addr 0 = 0xFFFFFFFF, then reserve addr 0 -> rd_data = 0 and rd_busy = 0 at all times.
- Fill regs 1..3 with 0x11, 0x22, 0x33, then clr_req -> init_busy high 32 cycles, writes during it ignored, regs read 0 afterwards. clr_req again at INIT cycle 10 -> INIT ends 32 cycles after the restart.
- Assert rst at INIT cycle 20, hold 3 cycles, release -> init_busy = 1 for 32 full cycles from release.
